// File: rtl/traffic_actuated_scheduler.sv
// rtl/traffic_actuated_scheduler.sv - demand-actuated round-robin phase scheduler for a 4-approach intersection
// Optional emergency preemption is enabled by defining TRAFFIC_EMERG_PREEMPT_EN.
module traffic_actuated_scheduler #(
    parameter int MIN_GREEN    = 5,
    parameter int GAP_TIME     = 3,
    parameter int MAX_GREEN    = 15,
    parameter int YELLOW_TIME  = 2,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] det,
    input  logic [3:0] ped_req,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    input  logic       emerg_req,
    input  logic [1:0] emerg_dir,
`endif
    output logic [3:0] green,
    output logic [3:0] yellow,
    output logic [3:0] red,
    output logic [3:0] walk,
    output logic [1:0] cur_phase,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_t;

    localparam logic [7:0] GAP_T  = 8'(GAP_TIME);
    localparam logic [7:0] WALK_T = 8'(WALK_TIME);

    state_t     st_q, st_d;
    logic [1:0] phase_d, rr_pick, cand, emerg_tgt;
    logic [7:0] timer_q, gap_q, gap_d, gap_run;
    logic [3:0] dmd_q, dmd_d, pdm_q, pdm_d;
    logic [3:0] cur_mask, enter_mask, pending;
    logic       walk_q, enter_green, rr_hit, conflict, emerg_act;

    // True once the state has lasted n cycles including the current one.
    function automatic logic reached(input logic [7:0] t, input int n);
        return ({1'b0, t} + 9'd1) >= 9'(n);
    endfunction

`ifdef TRAFFIC_EMERG_PREEMPT_EN
    assign emerg_act = emerg_req;
    assign emerg_tgt = emerg_dir;
`else
    assign emerg_act = 1'b0;
    assign emerg_tgt = 2'd0;
`endif

    assign cur_mask = 4'b0001 << cur_phase;
    assign pending  = dmd_q | pdm_q;
    assign conflict = |(pending & ~cur_mask);
    // Idle run length counting the current cycle, so a detector hit resets it immediately.
    assign gap_run  = det[cur_phase] ? 8'd0 : ((gap_q >= GAP_T) ? GAP_T : gap_q + 8'd1);

    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = cur_phase;
        cand    = cur_phase;
        for (int k = 1; k <= 4; k++) begin
            cand = cur_phase + 2'(k);
            if (!rr_hit && pending[cand]) begin
                rr_hit  = 1'b1;
                rr_pick = cand;
            end
        end
    end

    always_comb begin
        st_d    = st_q;
        phase_d = cur_phase;
        gap_d   = 8'd0;
        case (st_q)
            ST_ALL_RED: begin
                if (reached(timer_q, ALL_RED_TIME)) begin
                    if (emerg_act) begin
                        st_d    = ST_GREEN;
                        phase_d = emerg_tgt;
                    end else if (rr_hit) begin
                        st_d    = ST_GREEN;
                        phase_d = rr_pick;
                    end
                end
            end
            ST_GREEN: begin
                gap_d = gap_run;
                if (emerg_act) begin
                    if (emerg_tgt != cur_phase) st_d = ST_YELLOW;
                end else if (reached(timer_q, MIN_GREEN) && conflict &&
                             (gap_run >= GAP_T || reached(timer_q, MAX_GREEN))) begin
                    st_d = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (reached(timer_q, YELLOW_TIME)) st_d = ST_ALL_RED;
            end
            default: st_d = ST_ALL_RED;
        endcase
    end

    assign enter_green = (st_d == ST_GREEN) && (st_q != ST_GREEN);
    assign enter_mask  = enter_green ? (4'b0001 << phase_d) : 4'b0000;
    assign dmd_d = (dmd_q | (det & ~((st_q == ST_GREEN) ? cur_mask : 4'b0000))) & ~enter_mask;
    assign pdm_d = (pdm_q | ped_req) & ~enter_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= ST_ALL_RED;
            cur_phase <= 2'd0;
            timer_q   <= 8'd0;
            gap_q     <= 8'd0;
            dmd_q     <= 4'b0000;
            pdm_q     <= 4'b0000;
            walk_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            cur_phase <= phase_d;
            if (st_d != st_q) timer_q <= 8'd0;
            else if (timer_q != 8'hFF) timer_q <= timer_q + 8'd1;
            gap_q <= gap_d;
            dmd_q <= dmd_d;
            pdm_q <= pdm_d;
            if (enter_green) walk_q <= pdm_q[phase_d];
        end
    end

    always_comb begin
        green  = 4'b0000;
        yellow = 4'b0000;
        red    = 4'b1111;
        walk   = 4'b0000;
        case (st_q)
            ST_GREEN: begin
                green = cur_mask;
                red   = ~cur_mask;
                walk  = (walk_q && timer_q < WALK_T) ? cur_mask : 4'b0000;
            end
            ST_YELLOW: begin
                yellow = cur_mask;
                red    = ~cur_mask;
            end
            default: ;
        endcase
    end

    assign state = st_q;

endmodule

// File: tb/tb_traffic_actuated_scheduler.sv
// tb/tb_traffic_actuated_scheduler.sv - self-checking bench for traffic_actuated_scheduler
// Covers emergency preemption when TRAFFIC_EMERG_PREEMPT_EN is defined.
module tb_traffic_actuated_scheduler;

    localparam int MIN_GREEN    = 5;
    localparam int GAP_TIME     = 3;
    localparam int MAX_GREEN    = 15;
    localparam int YELLOW_TIME  = 2;
    localparam int ALL_RED_TIME = 1;
    localparam int WALK_TIME    = 4;

    // {red, yellow, green} light patterns
    localparam logic [11:0] V_G0 = 12'hE01;
    localparam logic [11:0] V_G1 = 12'hD02;
    localparam logic [11:0] V_G2 = 12'hB04;
    localparam logic [11:0] V_G3 = 12'h708;
    localparam logic [11:0] V_Y0 = 12'hE10;
    localparam logic [11:0] V_Y1 = 12'hD20;
    localparam logic [11:0] V_AR = 12'hF00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] det = 4'b0000;
    logic [3:0] ped_req = 4'b0000;
    logic [3:0] green, yellow, red, walk;
    logic [1:0] cur_phase, state;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    logic       emerg_req = 1'b0;
    logic [1:0] emerg_dir = 2'd0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    traffic_actuated_scheduler #(
        .MIN_GREEN(MIN_GREEN), .GAP_TIME(GAP_TIME), .MAX_GREEN(MAX_GREEN),
        .YELLOW_TIME(YELLOW_TIME), .ALL_RED_TIME(ALL_RED_TIME), .WALK_TIME(WALK_TIME)
    ) dut (
        .clk(clk), .rst(rst), .det(det), .ped_req(ped_req),
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        .emerg_req(emerg_req), .emerg_dir(emerg_dir),
`endif
        .green(green), .yellow(yellow), .red(red), .walk(walk),
        .cur_phase(cur_phase), .state(state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: state 0 all-red, 1 green, 2 yellow; m_cyc = cycles already spent in the state.
    int         m_st, m_ph, m_cyc, m_idle;
    bit [3:0]   m_dmd, m_pdm;
    bit         m_walk;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model
        int       ns, np, idle;
        bit [3:0] pend, nd, npd;
        bit       emerg;
        int       edir;
        if (rst) begin
            m_st = 0; m_ph = 0; m_cyc = 0; m_idle = 0;
            m_dmd = 0; m_pdm = 0; m_walk = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            pend  = m_dmd | m_pdm;
            ns    = m_st;
            np    = m_ph;
            idle  = 0;
            emerg = 1'b0;
            edir  = 0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            emerg = emerg_req;
            edir  = int'(emerg_dir);
`endif
            nd  = m_dmd;
            npd = m_pdm | ped_req;
            for (int i = 0; i < 4; i++)
                if (det[i] && !(m_st == 1 && m_ph == i)) nd[i] = 1'b1;
            case (m_st)
                0: if (m_cyc + 1 >= ALL_RED_TIME) begin
                    if (emerg) begin
                        ns = 1; np = edir;
                    end else begin
                        for (int k = 1; k <= 4; k++)
                            if (ns == 0 && pend[(m_ph + k) % 4]) begin
                                ns = 1; np = (m_ph + k) % 4;
                            end
                    end
                end
                1: begin
                    idle = det[m_ph] ? 0 : ((m_idle + 1 > GAP_TIME) ? GAP_TIME : m_idle + 1);
                    if (emerg) begin
                        if (edir != m_ph) ns = 2;
                    end else begin
                        bit conf;
                        conf = 1'b0;
                        for (int j = 0; j < 4; j++)
                            if (j != m_ph && pend[j]) conf = 1'b1;
                        if (m_cyc + 1 >= MIN_GREEN && conf &&
                            (idle >= GAP_TIME || m_cyc + 1 >= MAX_GREEN)) ns = 2;
                    end
                end
                default: if (m_cyc + 1 >= YELLOW_TIME) ns = 0;
            endcase
            if (ns == 1 && m_st != 1) begin
                m_walk  = m_pdm[np];
                nd[np]  = 1'b0;
                npd[np] = 1'b0;
            end
            m_idle = (ns == 1 && m_st == 1) ? idle : 0;
            m_cyc  = (ns != m_st) ? 0 : ((m_cyc >= 255) ? 255 : m_cyc + 1);
            m_st   = ns;
            m_ph   = np;
            m_dmd  = nd;
            m_pdm  = npd;
        end
    end

    function automatic logic [19:0] model_vec();
        logic [3:0] m, g, y, r, w;
        m = 4'b0001 << m_ph;
        g = (m_st == 1) ? m : 4'b0000;
        y = (m_st == 2) ? m : 4'b0000;
        r = (m_st == 0) ? 4'b1111 : ~m;
        w = (m_st == 1 && m_walk && m_cyc < WALK_TIME) ? m : 4'b0000;
        return {2'(m_st), 2'(m_ph), w, r, y, g};
    endfunction

    always @(negedge clk) begin
        if (m_valid)
            check("model_cycle", 32'({state, cur_phase, walk, red, yellow, green}), 32'(model_vec()));
    end

    function automatic logic [11:0] vec();
        return {red, yellow, green};
    endfunction

    // Waits for light pattern val, then counts its consecutive cycles, driving {ped_req,det}
    // with pv1/pv2 at green-relative cycles pk1/pk2 and with base otherwise.
    task automatic measure(input logic [11:0] val, input int pk1, input logic [7:0] pv1,
                           input int pk2, input logic [7:0] pv2, input logic [7:0] base,
                           input int cap, output int n, output int wcnt, output logic [11:0] after);
        int w;
        n = 0; wcnt = 0; w = 0;
        while (vec() != val && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (vec() == val && n < cap) begin
            {ped_req, det} = (n == pk1) ? pv1 : ((n == pk2) ? pv2 : base);
            if (walk != 4'b0000) wcnt++;
            n++;
            @(negedge clk);
        end
        {ped_req, det} = base;
        after = vec();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        int n, wc, gcnt;
        logic [11:0] after;

        repeat (3) @(negedge clk);
        check("reset_red", 32'(red), 32'hF);
        check("reset_state", 32'(state), 32'h0);
        check("reset_phase", 32'(cur_phase), 32'h0);
        rst = 1'b0;

        gcnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (green != 4'b0000 || red != 4'b1111) gcnt++;
        end
        check("idle_no_green", 32'(gcnt), 32'h0);

        det = 4'b0100;
        @(negedge clk);
        det = 4'b0000;
        measure(V_G2, -1, 8'h00, -1, 8'h00, 8'h00, 110, n, wc, after);
        check("rest_green2_len", 32'(n), 32'd110);
        check("rest_green2_walk", 32'(wc), 32'd0);

        det = 4'b0011;
        measure(V_G0, -1, 8'h00, -1, 8'h00, 8'h01, 300, n, wc, after);
        check("max_green0_len", 32'(n), 32'd15);
        check("max_green0_after", 32'(after), 32'(V_Y0));
        measure(V_Y0, -1, 8'h00, -1, 8'h00, 8'h01, 50, n, wc, after);
        check("yellow0_len", 32'(n), 32'd2);
        measure(V_AR, -1, 8'h00, -1, 8'h00, 8'h00, 50, n, wc, after);
        check("all_red_len", 32'(n), 32'd1);
        check("all_red_then_green1", 32'(after), 32'(V_G1));

        measure(V_G1, -1, 8'h00, -1, 8'h00, 8'h00, 300, n, wc, after);
        check("gap_green1_len", 32'(n), 32'd5);
        measure(V_G0, 0, 8'h08, -1, 8'h00, 8'h00, 300, n, wc, after);
        check("min_green0_len", 32'(n), 32'd5);
        measure(V_G3, 0, 8'h01, -1, 8'h00, 8'h00, 300, n, wc, after);
        check("min_green3_len", 32'(n), 32'd5);
        measure(V_G0, 0, 8'h08, 4, 8'h01, 8'h00, 300, n, wc, after);
        check("gap_ext_green0_len", 32'(n), 32'd8);

        measure(V_G3, 0, 8'h02, -1, 8'h00, 8'h00, 300, n, wc, after);
        check("green3_to_1_len", 32'(n), 32'd5);
        measure(V_G1, 0, 8'h89, -1, 8'h00, 8'h00, 300, n, wc, after);
        check("green1_len", 32'(n), 32'd5);
        check("green1_walk", 32'(wc), 32'd0);
        measure(V_G3, -1, 8'h00, -1, 8'h00, 8'h00, 300, n, wc, after);
        check("rr_green3_len", 32'(n), 32'd5);
        check("walk3_cycles", 32'(wc), 32'd4);
        measure(V_G0, -1, 8'h00, -1, 8'h00, 8'h00, 20, n, wc, after);
        check("rr_then_green0", 32'(n), 32'd20);

`ifdef TRAFFIC_EMERG_PREEMPT_EN
        det = 4'b0010;
        measure(V_G1, -1, 8'h00, -1, 8'h00, 8'h00, 1, n, wc, after);
        emerg_req = 1'b1;
        emerg_dir = 2'd2;
        check("emerg_green1_timer1", 32'(vec()), 32'(V_G1));
        @(negedge clk);
        measure(V_Y1, -1, 8'h00, -1, 8'h00, 8'h01, 50, n, wc, after);
        check("emerg_yellow1_len", 32'(n), 32'd2);
        measure(V_AR, -1, 8'h00, -1, 8'h00, 8'h01, 50, n, wc, after);
        check("emerg_all_red_len", 32'(n), 32'd1);
        check("emerg_then_green2", 32'(after), 32'(V_G2));
        measure(V_G2, -1, 8'h00, -1, 8'h00, 8'h01, 30, n, wc, after);
        check("emerg_hold_green2", 32'(n), 32'd30);
        emerg_req = 1'b0;
`endif

        det = 4'b0010;
        gcnt = 0;
        while (yellow == 4'b0000 && gcnt < 100) begin
            @(negedge clk);
            gcnt++;
        end
        check("reached_yellow", 32'(yellow != 4'b0000), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_red", 32'(red), 32'hF);
        check("midreset_state", 32'(state), 32'h0);
        rst = 1'b0;
        det = 4'b0000;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
